// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared constants and FSM state encoding for the instruction cache
package inst_cache_pkg;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage with combinational read and synchronous write
module icache_array #(
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] raddr,
  output logic                   rvalid,
  output logic [TAG_WIDTH-1:0]   rtag,
  output logic [31:0]            rdata,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] waddr,
  input  logic [TAG_WIDTH-1:0]   wtag,
  input  logic [31:0]            wdata
);
  localparam int LINES = 1 << INDEX_WIDTH;
  logic [LINES-1:0] valid;
  logic [TAG_WIDTH-1:0] tags [LINES];
  logic [31:0] data [LINES];
  assign rvalid = valid[raddr];
  assign rtag = tags[raddr];
  assign rdata = data[raddr];
  always_ff @(posedge clk)
    if (rst) valid <= '0;
    else if (we) valid[waddr] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[waddr] <= wtag;
      data[waddr] <= wdata;
    end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped one-word-per-line instruction cache with miss refill handshake
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counter ports.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH = 32 - INDEX_WIDTH - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic        busy,
  output logic        pc_miss_sgn,
  output logic [31:0] pc_out,
  input  logic        finish_ins,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  input  logic [31:0] ins_in
);
  state_t state;
  logic rvalid, hit, we;
  logic [TAG_WIDTH-1:0] rtag;
  logic [31:0] rdata;
  icache_array #(.INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)) array (
    .clk(clk), .rst(rst),
    .raddr(fetch_pc[INDEX_WIDTH+1:2]), .rvalid(rvalid), .rtag(rtag), .rdata(rdata),
    .we(we), .waddr(pc_out[INDEX_WIDTH+1:2]), .wtag(pc_out[31:INDEX_WIDTH+2]), .wdata(ins_in)
  );
  assign hit = rvalid && rtag == fetch_pc[31:INDEX_WIDTH+2];
  assign busy = state == MISS;
  // Dropping in the finish_ins cycle keeps memory_control from launching a second fetch
  assign pc_miss_sgn = busy && !(finish_ins && rdy);
  assign we = rdy && !rollback && busy && finish_ins;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      inst_valid <= FALSE;
      inst_out <= '0;
      pc_out <= '0;
    end else if (rdy) begin
      if (rollback) begin
        state <= IDLE;
        inst_valid <= FALSE;
      end else if (state == IDLE) begin
        inst_valid <= fetch_req && hit;
        if (fetch_req && hit) inst_out <= rdata;
        if (fetch_req && !hit) begin
          state <= MISS;
          pc_out <= fetch_pc & ~32'h3;
        end
      end else begin
        inst_valid <= finish_ins;
        if (finish_ins) begin
          inst_out <= ins_in;
          state <= IDLE;
        end
      end
    end
`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (rdy && !rollback && state == IDLE && fetch_req) begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      else miss_cnt <= miss_cnt + 32'd1;
    end
`endif
endmodule
